// File: rtl/serial_link_pkg.sv
// Shared definitions for the two-wire position link. The serializer and the
// deserializer both import this so the frame format lives in one place.
package serial_link_pkg;

   // Data bits per frame.
   localparam int unsigned POS_WIDTH = 10;

   // clk cycles without an SCL edge inside a frame before the frame is aborted.
   localparam int unsigned DEFAULT_TIMEOUT = 64;

   // Receive-side frame state.
   typedef enum logic [1:0] {
      StIdle,
      StData,
      StWaitStop
   } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus one delay flop for an asynchronous, idle-high
// link wire. Rise/fall are decoded from the synchronized and delayed samples.
module sync_edge
   import serial_link_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic sync_o,
   output logic dly_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   // Synchronizer chain; resets to the idle level so no edge appears on reset release.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         dly_q  <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   // Edge decode from the synchronized sample and its one-cycle-old copy.
   always_comb begin
      sync_o = sync_q;
      dly_o  = dly_q;
      rise_o = sync_q & ~dly_q;
      fall_o = ~sync_q & dly_q;
   end

endmodule

// File: rtl/serial_input.sv
// Receive-side deserializer for the two-wire position link. Detects start/stop
// framing on the oversampled SCL/SDA pair, shifts in an MSB-first word and
// presents it as a registered Position with a one-cycle valid strobe.
module serial_input
   import serial_link_pkg::*;
#(
   parameter int unsigned WIDTH   = POS_WIDTH,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             SCL,
   input  logic             SDA,
   output logic [WIDTH-1:0] Position,
   output logic             valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned ToW  = $clog2(TIMEOUT);

   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
   localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT - 1);

   // Conditioned link signals.
   logic scl_s, scl_dly, scl_rise, scl_fall;
   logic sda_s, sda_dly, sda_rise, sda_fall;
   logic unused_sda_dly;

   // Decoded link events.
   logic scl_high;
   logic start_ev;
   logic stop_ev;
   logic timeout_hit;

   // State and datapath.
   rx_state_t        state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]  bitcnt_q, bitcnt_d;
   logic [ToW-1:0]   to_q, to_d;
   logic             armed_q, armed_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   sync_edge u_sync_scl (
      .clk_i  (clk),
      .rst_i  (reset),
      .d_i    (SCL),
      .sync_o (scl_s),
      .dly_o  (scl_dly),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   sync_edge u_sync_sda (
      .clk_i  (clk),
      .rst_i  (reset),
      .d_i    (SDA),
      .sync_o (sda_s),
      .dly_o  (sda_dly),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   assign unused_sda_dly = sda_dly;

   // Start/stop need SCL stably high for two samples, so an SDA change that
   // coincides with an SCL rise is always treated as data.
   always_comb begin
      scl_high    = scl_s & scl_dly;
      start_ev    = scl_high & sda_fall;
      stop_ev     = scl_high & sda_rise;
      timeout_hit = (to_q == ToMax);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state, shift/bit-count updates and strobe generation.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      armed_d  = armed_q;
      pos_d    = pos_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_ev) begin
               state_d  = StData;
               shift_d  = '0;
               bitcnt_d = '0;
               armed_d  = 1'b0;
            end
         end

         StData: begin
            if (start_ev) begin
               // Repeated start: abort and resync on the new frame at once.
               err_d    = 1'b1;
               shift_d  = '0;
               bitcnt_d = '0;
            end else if (stop_ev) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else if (scl_rise) begin
               shift_d  = {shift_q[WIDTH-2:0], sda_s};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == LastBit) begin
                  state_d = StWaitStop;
                  armed_d = 1'b0;
               end
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end

         StWaitStop: begin
            if (start_ev) begin
               err_d    = 1'b1;
               state_d  = StData;
               shift_d  = '0;
               bitcnt_d = '0;
            end else if (stop_ev) begin
               pos_d   = shift_q;
               valid_d = 1'b1;
               state_d = StIdle;
            end else if (scl_rise) begin
               // The first rise here is the clock that sets up the stop; a
               // second one means the sender clocked an extra data bit.
               if (armed_q) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  armed_d = 1'b1;
               end
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Timeout counter: restarts on any SCL edge or new frame, saturates at the limit.
   always_comb begin
      to_d = to_q;
      if (state_q == StIdle || scl_rise || scl_fall || start_ev) begin
         to_d = '0;
      end else if (!timeout_hit) begin
         to_d = to_q + 1'b1;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q  <= '0;
         bitcnt_q <= '0;
         to_q     <= '0;
         armed_q  <= 1'b0;
         pos_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         to_q     <= to_d;
         armed_q  <= armed_d;
         pos_q    <= pos_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   // Outputs: busy follows the registered state, strobes are registered.
   always_comb begin
      busy      = (state_q != StIdle);
      Position  = pos_q;
      valid     = valid_q;
      frame_err = err_q;
   end

endmodule

// File: tb/tb_serial_input.sv
// Directed bench for serial_input: drives framed words on SCL/SDA and checks
// Position, strobes, busy and the 3-edge latencies against hand-computed values.
module tb_serial_input;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl;
   logic       sda;
   logic [9:0] position;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int n_chk   = 0;
   int n_pass  = 0;
   int n_valid = 0;
   int n_err   = 0;
   int n_both  = 0;

   always #5 clk = ~clk;

   serial_input #(
      .WIDTH   (10),
      .TIMEOUT (64)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .SCL       (scl),
      .SDA       (sda),
      .Position  (position),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // Pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (valid) n_valid <= n_valid + 1;
      if (frame_err) n_err <= n_err + 1;
      if (valid && frame_err) n_both <= n_both + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_chk++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
   endtask

   // Returns 2 time units after the n-th rising edge.
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Start with SCL high: SDA falls, then SCL falls.
   task automatic do_start(input bit chk_lat);
      sda = 1'b0;
      if (chk_lat) begin
         repeat (2) @(posedge clk);
         #1 check_eq("busy_before_lat", busy, 0);
         @(posedge clk);
         #1 check_eq("busy_at_lat", busy, 1);
         #1;
         wait_clk(1);
      end else begin
         wait_clk(4);
      end
      scl = 1'b0;
      wait_clk(4);
   endtask

   task automatic send_bit(input bit b);
      sda = b;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
      scl = 1'b0;
      wait_clk(2);
   endtask

   // Sends the top nbits of w, MSB first.
   task automatic send_word(input logic [9:0] w, input int nbits);
      for (int i = 9; i > 9 - nbits; i--) send_bit(w[i]);
   endtask

   // Stop from SCL low; checks both strobes exactly 3 edges after SDA goes high.
   task automatic send_stop(input string tag, input bit exp_v, input bit exp_e);
      sda = 1'b0;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
      sda = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq({tag, "_valid_early"}, valid, 0);
      check_eq({tag, "_err_early"}, frame_err, 0);
      @(posedge clk);
      #1;
      check_eq({tag, "_valid"}, valid, exp_v);
      check_eq({tag, "_err"}, frame_err, exp_e);
      @(posedge clk);
      #1;
      check_eq({tag, "_valid_width"}, valid, 0);
      check_eq({tag, "_err_width"}, frame_err, 0);
      #1;
      wait_clk(4);
   endtask

   // Return both wires high from any state, with SCL low first.
   task automatic go_idle();
      sda = 1'b0;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
      sda = 1'b1;
      wait_clk(6);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: sim time %0t exceeded, required finish before 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0;
      int e0;

      scl   = 1'b1;
      sda   = 1'b1;
      reset = 1'b1;
      wait_clk(3);
      check_eq("rst_position", position, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_err", frame_err, 0);
      check_eq("rst_busy", busy, 0);
      reset = 1'b0;
      wait_clk(4);

      // All-ones frame.
      v0 = n_valid; e0 = n_err;
      do_start(1'b1);
      send_word(10'h3FF, 10);
      send_stop("f3ff", 1'b1, 1'b0);
      check_eq("f3ff_position", position, 10'h3FF);
      check_eq("f3ff_busy", busy, 0);
      check_eq("f3ff_nvalid", n_valid - v0, 1);
      check_eq("f3ff_nerr", n_err - e0, 0);

      // Back-to-back 681 then 1023.
      v0 = n_valid;
      do_start(1'b0);
      send_word(10'h2A9, 10);
      send_stop("f2a9", 1'b1, 1'b0);
      check_eq("f2a9_position", position, 10'h2A9);
      check_eq("b2b_busy_gap", busy, 0);
      do_start(1'b0);
      send_word(10'h3FF, 10);
      send_stop("b2b3ff", 1'b1, 1'b0);
      check_eq("b2b_position", position, 10'h3FF);
      check_eq("b2b_nvalid", n_valid - v0, 2);

      // Good 681 frame, then a 5-bit frame ended by stop.
      do_start(1'b0);
      send_word(10'h2A9, 10);
      send_stop("pre_short", 1'b1, 1'b0);
      v0 = n_valid; e0 = n_err;
      do_start(1'b0);
      send_word(10'h3E0, 5);
      send_stop("short", 1'b0, 1'b1);
      check_eq("short_position", position, 10'h2A9);
      check_eq("short_busy", busy, 0);
      check_eq("short_nvalid", n_valid - v0, 0);
      check_eq("short_nerr", n_err - e0, 1);

      // Repeated start after 6 bits, then a full 0x155 frame.
      e0 = n_err;
      do_start(1'b0);
      send_word(10'h2A9, 6);
      sda = 1'b1;
      wait_clk(4);
      scl = 1'b1;
      wait_clk(4);
      do_start(1'b0);
      check_eq("rstart_nerr", n_err - e0, 1);
      check_eq("rstart_busy", busy, 1);
      send_word(10'h155, 10);
      send_stop("rstart_f155", 1'b1, 1'b0);
      check_eq("rstart_position", position, 10'h155);

      // SCL held low for 70 clk mid-frame.
      v0 = n_valid; e0 = n_err;
      do_start(1'b0);
      send_word(10'h3FF, 3);
      wait_clk(70);
      check_eq("to_nerr", n_err - e0, 1);
      check_eq("to_busy", busy, 0);
      check_eq("to_nvalid", n_valid - v0, 0);
      check_eq("to_position", position, 10'h155);
      go_idle();
      do_start(1'b0);
      send_word(10'h2A9, 10);
      send_stop("post_to", 1'b1, 1'b0);
      check_eq("post_to_position", position, 10'h2A9);
      check_eq("post_to_nerr", n_err - e0, 1);

      // Eleventh data clock after a full word aborts the frame.
      v0 = n_valid; e0 = n_err;
      do_start(1'b0);
      send_word(10'h155, 10);
      send_bit(1'b0);
      send_bit(1'b0);
      wait_clk(4);
      check_eq("extra_nerr", n_err - e0, 1);
      check_eq("extra_busy", busy, 0);
      check_eq("extra_nvalid", n_valid - v0, 0);
      check_eq("extra_position", position, 10'h2A9);
      go_idle();

      // One-cycle reset at bit 4 of a frame.
      e0 = n_err;
      do_start(1'b0);
      send_word(10'h2A9, 4);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midrst_position", position, 0);
      check_eq("midrst_valid", valid, 0);
      check_eq("midrst_err", frame_err, 0);
      check_eq("midrst_busy", busy, 0);
      #1 reset = 1'b0;
      wait_clk(4);
      go_idle();
      check_eq("midrst_nerr", n_err - e0, 0);
      check_eq("midrst_idle_busy", busy, 0);
      do_start(1'b0);
      send_word(10'h3FF, 10);
      send_stop("post_rst", 1'b1, 1'b0);
      check_eq("post_rst_position", position, 10'h3FF);

      check_eq("valid_err_overlap", n_both, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
